// File: rtl/params_pkg.sv
// Shared bus widths and access-size encoding for the CPU/memory interface.
package params_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

endpackage

// File: rtl/mem_latency_ctrl.sv
// Single-outstanding request controller that delays CPU accesses by a fixed
// latency before issuing them to imem, and returns read data as a one-cycle pulse.
module mem_latency_ctrl #(
  parameter int LATENCY    = 4,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rd_req_valid_i,
  input  logic                           wr_req_valid_i,
  input  logic                           req_is_instr_i,
  input  logic [ADDR_WIDTH-1:0]          req_address_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  input  params_pkg::access_size_t       req_access_size_i,
  output logic                           data_valid_o,
  output logic                           data_is_instr_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           busy_o,
  output logic                           mem_rd_req_valid_o,
  output logic                           mem_wr_req_valid_o,
  output logic                           mem_req_is_instr_o,
  output logic [ADDR_WIDTH-1:0]          mem_address_o,
  output logic [DATA_WIDTH-1:0]          mem_wr_data_o,
  output params_pkg::access_size_t       mem_access_size_o,
  input  logic                           mem_data_valid_i,
  input  logic                           mem_data_is_instr_i,
  input  logic [DATA_WIDTH-1:0]          mem_data_i,
  output logic [31:0]                    rd_count_o,
  output logic [31:0]                    wr_count_o,
  output logic                           dropped_o
);

  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT      = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_RESP_WAIT = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]               state;
  logic [CNT_W-1:0]         cnt;
  logic                     req_wr;
  logic                     req_instr;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  params_pkg::access_size_t req_size;
  logic [DATA_WIDTH-1:0]    resp_data;
  logic                     resp_instr;
  logic [31:0]              rd_count;
  logic [31:0]              wr_count;
  logic                     dropped;

  logic any_req;
  assign any_req = rd_req_valid_i || wr_req_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values regardless of statement order.
      state      <= S_IDLE;
      cnt        <= '0;
      req_wr     <= 1'b0;
      req_instr  <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_size   <= params_pkg::SIZE_BYTE;
      resp_data  <= '0;
      resp_instr <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      dropped    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            // A simultaneous read and write keeps the read and drops the write.
            req_wr    <= !rd_req_valid_i;
            req_instr <= req_is_instr_i;
            req_addr  <= req_address_i;
            req_wdata <= wr_data_i;
            req_size  <= req_access_size_i;
            cnt       <= CNT_INIT;
            state     <= (LATENCY == 0) ? S_ISSUE : S_WAIT;
            if (rd_req_valid_i && wr_req_valid_i) dropped <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (req_wr) begin
            wr_count <= wr_count + 32'd1;
            state    <= S_IDLE;
          end else if (mem_data_valid_i) begin
            // Zero-latency imem answers in the issue cycle itself.
            resp_data  <= mem_data_i;
            resp_instr <= mem_data_is_instr_i;
            state      <= S_RESP;
          end else begin
            state <= S_RESP_WAIT;
          end
        end
        S_RESP_WAIT: begin
          if (mem_data_valid_i) begin
            resp_data  <= mem_data_i;
            resp_instr <= mem_data_is_instr_i;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          rd_count <= rd_count + 32'd1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if ((state != S_IDLE) && any_req) dropped <= 1'b1;
    end
  end

  assign busy_o             = (state != S_IDLE);
  assign data_valid_o       = (state == S_RESP);
  assign data_is_instr_o    = resp_instr;
  assign data_o             = resp_data;
  assign mem_rd_req_valid_o = (state == S_ISSUE) && !req_wr;
  assign mem_wr_req_valid_o = (state == S_ISSUE) && req_wr;
  assign mem_req_is_instr_o = req_instr;
  assign mem_address_o      = req_addr;
  assign mem_wr_data_o      = req_wdata;
  assign mem_access_size_o  = req_size;
  assign rd_count_o         = rd_count;
  assign wr_count_o         = wr_count;
  assign dropped_o          = dropped;

endmodule

// File: tb/tb_mem_latency_ctrl.sv
// Directed bench for mem_latency_ctrl: a LATENCY=4 instance and a LATENCY=0
// instance, each in front of a small behavioural imem.
module tb_mem_latency_ctrl;
  import params_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         rd4 = 1'b0, wr4 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic         req_instr = 1'b0;
  logic [31:0]  req_addr = '0, wdata = '0;
  access_size_t req_size = SIZE_WORD;
  logic         zl0 = 1'b0;

  // LATENCY=4 instance signals
  logic dv4, di4, b4, m4_rd, m4_wr, m4_isi, dr4;
  logic [31:0] d4, m4_addr, m4_wdata, rc4, wc4;
  access_size_t m4_size;
  logic m4_dv, m4_di;
  logic [31:0] m4_d;

  // LATENCY=0 instance signals
  logic dv0, di0, b0, m0_rd, m0_wr, m0_isi, dr0;
  logic [31:0] d0, m0_addr, m0_wdata, rc0, wc0;
  access_size_t m0_size;
  logic m0_dv, m0_di, m0_dvq, m0_diq;
  logic [31:0] m0_d, m0_dq;

  mem_latency_ctrl #(.LATENCY(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .rd_req_valid_i(rd4), .wr_req_valid_i(wr4), .req_is_instr_i(req_instr),
    .req_address_i(req_addr), .wr_data_i(wdata), .req_access_size_i(req_size),
    .data_valid_o(dv4), .data_is_instr_o(di4), .data_o(d4), .busy_o(b4),
    .mem_rd_req_valid_o(m4_rd), .mem_wr_req_valid_o(m4_wr), .mem_req_is_instr_o(m4_isi),
    .mem_address_o(m4_addr), .mem_wr_data_o(m4_wdata), .mem_access_size_o(m4_size),
    .mem_data_valid_i(m4_dv), .mem_data_is_instr_i(m4_di), .mem_data_i(m4_d),
    .rd_count_o(rc4), .wr_count_o(wc4), .dropped_o(dr4)
  );

  mem_latency_ctrl #(.LATENCY(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .rd_req_valid_i(rd0), .wr_req_valid_i(wr0), .req_is_instr_i(req_instr),
    .req_address_i(req_addr), .wr_data_i(wdata), .req_access_size_i(req_size),
    .data_valid_o(dv0), .data_is_instr_o(di0), .data_o(d0), .busy_o(b0),
    .mem_rd_req_valid_o(m0_rd), .mem_wr_req_valid_o(m0_wr), .mem_req_is_instr_o(m0_isi),
    .mem_address_o(m0_addr), .mem_wr_data_o(m0_wdata), .mem_access_size_o(m0_size),
    .mem_data_valid_i(m0_dv), .mem_data_is_instr_i(m0_di), .mem_data_i(m0_d),
    .rd_count_o(rc0), .wr_count_o(wc0), .dropped_o(dr0)
  );

  // Word-addressed imem, reloaded on reset; only the LATENCY=4 instance writes it.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h000446F1;
      mem[2] <= 32'h00A00093;
      mem[3] <= 32'h00108113;
      mem[4] <= 32'h12345678;
    end else if (m4_wr) begin
      mem[m4_addr[7:2]] <= m4_wdata;
    end
    m4_dv  <= m4_rd;
    m4_d   <= mem[m4_addr[7:2]];
    m4_di  <= m4_isi;
    m0_dvq <= m0_rd && !zl0;
    m0_dq  <= mem[m0_addr[7:2]];
    m0_diq <= m0_isi;
  end
  assign m0_dv = zl0 ? m0_rd : m0_dvq;
  assign m0_d  = zl0 ? mem[m0_addr[7:2]] : m0_dq;
  assign m0_di = zl0 ? m0_isi : m0_diq;

  // Event monitor sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd4_n = 0, rd4_cyc = 0, wr4_n = 0, wr4_cyc = 0, dv4_n = 0, dv4_cyc = 0;
  int wr0_n = 0, dv0_n = 0, dv0_cyc = 0;
  logic [31:0] rd4_addr = '0, wr4_addr = '0, wr4_data = '0, dv4_data = '0;
  logic dv4_instr = 1'b0;
  access_size_t wr4_size = SIZE_BYTE;
  logic [31:0] dv0_q [$];

  always @(negedge clk) begin
    if (m4_rd) begin rd4_n <= rd4_n + 1; rd4_cyc <= cyc; rd4_addr <= m4_addr; end
    if (m4_wr) begin
      wr4_n <= wr4_n + 1; wr4_cyc <= cyc; wr4_addr <= m4_addr; wr4_data <= m4_wdata; wr4_size <= m4_size;
    end
    if (dv4) begin dv4_n <= dv4_n + 1; dv4_cyc <= cyc; dv4_data <= d4; dv4_instr <= di4; end
    if (m0_wr) wr0_n <= wr0_n + 1;
    if (dv0) begin dv0_n <= dv0_n + 1; dv0_cyc <= cyc; dv0_q.push_back(d0); end
  end

  int n_checks = 0, n_pass = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd4 = 1'b0; wr4 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic issue4(input logic rd, input logic wr, input logic instr,
                        input logic [31:0] addr, input logic [31:0] data, output int acc);
    rd4 = rd; wr4 = wr; req_instr = instr; req_addr = addr; wdata = data;
    acc = cyc;
    step();
    rd4 = 1'b0; wr4 = 1'b0;
  endtask

  task automatic wait_idle4(input string name);
    for (int i = 0; i < 40 && b4 !== 1'b0; i++) step();
    n_checks++; if (b4 !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b want 0", name, b4); else n_pass++;
  endtask

  task automatic wait_idle0(input string name);
    for (int i = 0; i < 40 && b0 !== 1'b0; i++) step();
    n_checks++; if (b0 !== 1'b0) $display("FAIL %s_idle_timeout: busy=%b want 0", name, b0); else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (b4 !== 1'b0) $display("FAIL rst_busy4: got %b want 0", b4); else n_pass++;
    n_checks++; if (dr4 !== 1'b0) $display("FAIL rst_dropped4: got %b want 0", dr4); else n_pass++;
    n_checks++; if ({dv4, m4_rd, m4_wr} !== 3'b000) $display("FAIL rst_valids4: got %b want 000", {dv4, m4_rd, m4_wr}); else n_pass++;
    n_checks++; if ({rc4, wc4} !== 64'h0) $display("FAIL rst_counts4: got %h want 0", {rc4, wc4}); else n_pass++;
    n_checks++; if ({d4, m4_addr, m4_wdata} !== 96'h0) $display("FAIL rst_payload4: got %h want 0", {d4, m4_addr, m4_wdata}); else n_pass++;
    n_checks++; if ({b0, dr0, dv0, m0_rd} !== 4'b0000) $display("FAIL rst_flags0: got %b want 0000", {b0, dr0, dv0, m0_rd}); else n_pass++;
  endtask

  task automatic test_read();
    int acc, rb, dvb, wb;
    rb = rd4_n; dvb = dv4_n; wb = wr4_n;
    issue4(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, acc);
    n_checks++; if (b4 !== 1'b1) $display("FAIL read_busy_next: got %b want 1", b4); else n_pass++;
    wait_idle4("read");
    n_checks++; if (rd4_n - rb != 1) $display("FAIL read_issue_count: got %0d want 1", rd4_n - rb); else n_pass++;
    n_checks++; if (rd4_cyc - acc != 5) $display("FAIL read_issue_delay: got %0d want 5", rd4_cyc - acc); else n_pass++;
    n_checks++; if (rd4_addr !== 32'h4) $display("FAIL read_issue_addr: got %h want 00000004", rd4_addr); else n_pass++;
    n_checks++; if (dv4_n - dvb != 1) $display("FAIL read_dv_pulses: got %0d want 1", dv4_n - dvb); else n_pass++;
    n_checks++; if (dv4_cyc - acc != 7) $display("FAIL read_dv_delay: got %0d want 7", dv4_cyc - acc); else n_pass++;
    n_checks++; if (dv4_data !== 32'h000446F1) $display("FAIL read_data: got %h want 000446f1", dv4_data); else n_pass++;
    n_checks++; if (dv4_instr !== 1'b1) $display("FAIL read_is_instr: got %b want 1", dv4_instr); else n_pass++;
    n_checks++; if (rc4 !== 32'd1) $display("FAIL read_rd_count: got %0d want 1", rc4); else n_pass++;
    n_checks++; if (wr4_n != wb) $display("FAIL read_no_write: got %0d writes want 0", wr4_n - wb); else n_pass++;
    n_checks++; if (d4 !== 32'h000446F1) $display("FAIL read_data_hold: got %h want 000446f1", d4); else n_pass++;
  endtask

  task automatic test_write();
    int acc, wb, dvb;
    wb = wr4_n; dvb = dv4_n;
    issue4(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, acc);
    wait_idle4("write");
    n_checks++; if (wr4_n - wb != 1) $display("FAIL write_pulses: got %0d want 1", wr4_n - wb); else n_pass++;
    n_checks++; if (wr4_cyc - acc != 5) $display("FAIL write_delay: got %0d want 5", wr4_cyc - acc); else n_pass++;
    n_checks++; if (wr4_addr !== 32'h40) $display("FAIL write_addr: got %h want 00000040", wr4_addr); else n_pass++;
    n_checks++; if (wr4_data !== 32'hDEADBEEF) $display("FAIL write_data: got %h want deadbeef", wr4_data); else n_pass++;
    n_checks++; if (wr4_size !== SIZE_WORD) $display("FAIL write_size: got %0d want %0d", wr4_size, SIZE_WORD); else n_pass++;
    n_checks++; if (dv4_n != dvb) $display("FAIL write_no_dv: got %0d pulses want 0", dv4_n - dvb); else n_pass++;
    n_checks++; if (wc4 !== 32'd1) $display("FAIL write_wr_count: got %0d want 1", wc4); else n_pass++;
    issue4(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, acc);
    wait_idle4("readback");
    n_checks++; if (dv4_data !== 32'hDEADBEEF) $display("FAIL readback_data: got %h want deadbeef", dv4_data); else n_pass++;
    n_checks++; if (dv4_instr !== 1'b0) $display("FAIL readback_is_instr: got %b want 0", dv4_instr); else n_pass++;
    n_checks++; if (rc4 !== 32'd2) $display("FAIL readback_rd_count: got %0d want 2", rc4); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] exp_d [3];
    int acc, dvb, qb, first_dv;
    addrs = '{32'h4, 32'h8, 32'hC};
    exp_d = '{32'h000446F1, 32'h00A00093, 32'h00108113};
    dvb = dv0_n; qb = dv0_q.size(); acc = 0; first_dv = 0;
    for (int i = 0; i < 3; i++) begin
      rd0 = 1'b1; req_instr = 1'b1; req_addr = addrs[i];
      if (i == 0) acc = cyc;
      step();
      rd0 = 1'b0;
      wait_idle0("b2b");
      if (i == 0) first_dv = dv0_cyc;
    end
    n_checks++; if (first_dv - acc != 3) $display("FAIL b2b_first_delay: got %0d want 3", first_dv - acc); else n_pass++;
    n_checks++; if (dv0_n - dvb != 3) $display("FAIL b2b_resp_count: got %0d want 3", dv0_n - dvb); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (dv0_q.size() <= qb + i) $display("FAIL b2b_resp%0d: got none want %h", i, exp_d[i]);
      else if (dv0_q[qb + i] !== exp_d[i]) $display("FAIL b2b_resp%0d: got %h want %h", i, dv0_q[qb + i], exp_d[i]);
      else n_pass++;
    end
    n_checks++; if (rc0 !== 32'd3) $display("FAIL b2b_rd_count: got %0d want 3", rc0); else n_pass++;
    n_checks++; if (dr0 !== 1'b0) $display("FAIL b2b_dropped: got %b want 0", dr0); else n_pass++;
    n_checks++; if (di0 !== 1'b1) $display("FAIL b2b_is_instr: got %b want 1", di0); else n_pass++;
    n_checks++; if (wr0_n != 0) $display("FAIL b2b_no_write: got %0d writes want 0", wr0_n); else n_pass++;
    n_checks++; if (m0_size !== SIZE_WORD || m0_wdata !== 32'h0) $display("FAIL b2b_payload: got size %0d data %h want 2/0", m0_size, m0_wdata); else n_pass++;
  endtask

  task automatic test_zero_latency_imem();
    int acc;
    zl0 = 1'b1;
    rd0 = 1'b1; req_instr = 1'b0; req_addr = 32'h8; acc = cyc;
    step();
    rd0 = 1'b0;
    wait_idle0("zl");
    zl0 = 1'b0;
    n_checks++; if (dv0_cyc - acc != 2) $display("FAIL zl_dv_delay: got %0d want 2", dv0_cyc - acc); else n_pass++;
    n_checks++; if (d0 !== 32'h00A00093) $display("FAIL zl_data: got %h want 00a00093", d0); else n_pass++;
    n_checks++; if (rc0 !== 32'd4) $display("FAIL zl_rd_count: got %0d want 4", rc0); else n_pass++;
  endtask

  task automatic test_drop_while_busy();
    int acc, rb, dvb;
    rb = rd4_n; dvb = dv4_n;
    issue4(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, acc);
    step();
    rd4 = 1'b1; req_addr = 32'hC;
    step();
    rd4 = 1'b0;
    wait_idle4("drop");
    n_checks++; if (dr4 !== 1'b1) $display("FAIL drop_flag: got %b want 1", dr4); else n_pass++;
    n_checks++; if (rd4_n - rb != 1) $display("FAIL drop_issue_count: got %0d want 1", rd4_n - rb); else n_pass++;
    n_checks++; if (rd4_addr !== 32'h8) $display("FAIL drop_issue_addr: got %h want 00000008", rd4_addr); else n_pass++;
    n_checks++; if (dv4_n - dvb != 1 || dv4_data !== 32'h00A00093) $display("FAIL drop_resp: got %0d/%h want 1/00a00093", dv4_n - dvb, dv4_data); else n_pass++;
    n_checks++; if (rc4 !== 32'd3) $display("FAIL drop_rd_count: got %0d want 3", rc4); else n_pass++;
    step(); step(); step();
    n_checks++; if (dr4 !== 1'b1) $display("FAIL drop_sticky: got %b want 1", dr4); else n_pass++;
  endtask

  task automatic test_rd_wr_same_cycle();
    int acc, rb, wb;
    do_reset();
    n_checks++; if (dr4 !== 1'b0) $display("FAIL rdwr_drop_cleared: got %b want 0", dr4); else n_pass++;
    rb = rd4_n; wb = wr4_n;
    issue4(1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFEF00D, acc);
    wait_idle4("rdwr");
    n_checks++; if (wr4_n != wb) $display("FAIL rdwr_no_write: got %0d writes want 0", wr4_n - wb); else n_pass++;
    n_checks++; if (rd4_n - rb != 1 || rd4_addr !== 32'h10) $display("FAIL rdwr_read_issued: got %0d@%h want 1@00000010", rd4_n - rb, rd4_addr); else n_pass++;
    n_checks++; if (dr4 !== 1'b1) $display("FAIL rdwr_dropped: got %b want 1", dr4); else n_pass++;
    n_checks++; if (dv4_data !== 32'h12345678) $display("FAIL rdwr_data: got %h want 12345678", dv4_data); else n_pass++;
    n_checks++; if (rc4 !== 32'd1 || wc4 !== 32'd0) $display("FAIL rdwr_counts: got %0d/%0d want 1/0", rc4, wc4); else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int acc, rb, dvb;
    rb = rd4_n; dvb = dv4_n;
    issue4(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, acc);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (b4 !== 1'b0) $display("FAIL rstwait_busy: got %b want 0", b4); else n_pass++;
    n_checks++; if (rc4 !== 32'd0 || wc4 !== 32'd0) $display("FAIL rstwait_counts: got %0d/%0d want 0/0", rc4, wc4); else n_pass++;
    n_checks++; if (dr4 !== 1'b0) $display("FAIL rstwait_dropped: got %b want 0", dr4); else n_pass++;
    for (int i = 0; i < 12; i++) step();
    n_checks++; if (rd4_n != rb) $display("FAIL rstwait_no_issue: got %0d reads want 0", rd4_n - rb); else n_pass++;
    n_checks++; if (dv4_n != dvb) $display("FAIL rstwait_no_dv: got %0d pulses want 0", dv4_n - dvb); else n_pass++;
    n_checks++; if (b4 !== 1'b0) $display("FAIL rstwait_stays_idle: got %b want 0", b4); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_zero_latency_imem();
    test_drop_while_busy();
    test_rd_wr_same_cycle();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
